// File: rtl/lock_pkg.sv
// lock_pkg: state encoding and protocol constants shared by the lock code sender and receiver.
package lock_pkg;
   localparam int LOCK_N_DIGITS = 4;
   localparam int LOCK_DIGIT_W  = 4;
   localparam int LOCK_GAP      = 2;
   localparam int LOCK_BTN_NEXT  = 0;
   localparam int LOCK_BTN_ENTER = 1;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_NEXT_P = 3'd1;
   localparam logic [2:0] ST_NEXT_G = 3'd2;
   localparam logic [2:0] ST_ENT_P  = 3'd3;
   localparam logic [2:0] ST_ENT_G  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      NEXT_P = ST_NEXT_P,
      NEXT_G = ST_NEXT_G,
      ENT_P  = ST_ENT_P,
      ENT_G  = ST_ENT_G,
      DONE   = ST_DONE
   } state_t;
endpackage

// File: rtl/lock_gap_timer.sv
// lock_gap_timer: reloads to GAP on load_i and flags the last of GAP enabled cycles.
module lock_gap_timer #(
   parameter int GAP = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = $clog2(GAP + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? CW'(GAP) : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   assign expired_o = en_i && cnt_q == CW'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/lock_code_sender.sv
// lock_code_sender: serialises a parallel N-digit code into next/enter pulses for the lock,
// highest digit first, each pulse followed by GAP idle cycles.
module lock_code_sender
   import lock_pkg::*;
#(
   parameter int N_DIGITS = LOCK_N_DIGITS,
   parameter int DIGIT_W  = LOCK_DIGIT_W,
   parameter int GAP      = LOCK_GAP
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic [N_DIGITS*DIGIT_W-1:0]  code_i,
   input  logic                         abort_i,
   output logic                         next_o,
   output logic                         enter_o,
   output logic                         busy_o,
   output logic                         done_o
);
   localparam int CW = N_DIGITS * DIGIT_W;
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   state_t             state_q, state_d;
   logic [CW-1:0]      shr_q, shr_d, shr_nx;
   logic [IW-1:0]      idx_q, idx_d;
   logic [DIGIT_W-1:0] cnt_q, cnt_d, dig_in, dig_nx;
   logic               gap_exp;
   // The digit being sent always sits in the top slot of the shift register.
   assign shr_nx = shr_q << DIGIT_W;
   assign dig_nx = shr_nx[CW-1 -: DIGIT_W];
   assign dig_in = code_i[CW-1 -: DIGIT_W];
   always_comb begin
      state_d = state_q;
      shr_d   = shr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            shr_d   = code_i;
            idx_d   = IW'(N_DIGITS - 1);
            cnt_d   = dig_in;
            state_d = dig_in != '0 ? NEXT_P : ENT_P;
         end
         NEXT_P: begin
            cnt_d   = cnt_q - 1'b1;
            state_d = NEXT_G;
         end
         NEXT_G: if (gap_exp) state_d = cnt_q != '0 ? NEXT_P : ENT_P;
         ENT_P:  state_d = ENT_G;
         ENT_G: if (gap_exp) begin
            if (idx_q == '0) state_d = DONE;
            else begin
               idx_d   = idx_q - 1'b1;
               shr_d   = shr_nx;
               cnt_d   = dig_nx;
               state_d = dig_nx != '0 ? NEXT_P : ENT_P;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_i && state_q != IDLE) state_d = IDLE;
   end
   assign next_o  = state_q == NEXT_P;
   assign enter_o = state_q == ENT_P;
   assign done_o  = state_q == DONE;
   assign busy_o  = state_q != IDLE && state_q != DONE;
   lock_gap_timer #(.GAP(GAP)) u_gap (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (next_o || enter_o),
      .en_i      (state_q == NEXT_G || state_q == ENT_G),
      .expired_o (gap_exp)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         shr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shr_q   <= shr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
endmodule

// File: tb/tb_lock_code_sender.sv
// tb_lock_code_sender: directed stimulus with a pulse scoreboard and a behavioural lock receiver.
module tb_lock_code_sender;
   import lock_pkg::*;
   localparam int GAP = 2;
   localparam logic [15:0] LOCK_CODE = 16'h2103;
   logic clk = 0, rst_n = 0, start_i = 0, abort_i = 0;
   logic [15:0] code_i = '0;
   logic next_o, enter_o, busy_o, done_o;
   int n_vec = 0, n_err = 0, cyc = 0;
   bit exp_q[$];
   int t_acc, exp_p, done_cyc, last_cyc, n_pulse, busy_cnt;
   bit done_flag;
   logic [15:0] exp_code, got_code;
   logic [3:0] dig_cnt;

   lock_code_sender #(.N_DIGITS(4), .DIGIT_W(4), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .code_i(code_i), .abort_i(abort_i),
      .next_o(next_o), .enter_o(enter_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer plus a receiver model: nexts count up a digit, enter commits it.
   always @(negedge clk) if (rst_n) begin
      if (next_o || enter_o) begin
         check("exclusive", {31'd0, next_o & enter_o}, 0);
         if (exp_q.size() == 0) check("pulse_expected", exp_q.size(), 1);
         else check("pulse_kind", {31'd0, enter_o}, {31'd0, exp_q.pop_front()});
         if (n_pulse == 0) check("first_latency", cyc, t_acc);
         else check("spacing", cyc - last_cyc, GAP + 1);
         last_cyc = cyc;
         n_pulse++;
         if (enter_o) begin
            got_code = {got_code[11:0], dig_cnt};
            dig_cnt  = 0;
         end else dig_cnt++;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
         done_flag = 1;
         done_cyc  = cyc;
         check("done_busy", {31'd0, busy_o}, 0);
      end
   end

   task automatic go(input logic [15:0] code, input bit ab);
      logic [3:0] d;
      exp_q.delete();
      exp_p = 0;
      exp_code = code;
      for (int i = 3; i >= 0; i--) begin
         d = code[4*i +: 4];
         repeat (d) exp_q.push_back(1'b0);
         exp_q.push_back(1'b1);
         exp_p += d + 1;
      end
      n_pulse = 0; busy_cnt = 0; done_flag = 0; got_code = '0; dig_cnt = '0;
      @(posedge clk); #1;
      start_i = 1; abort_i = ab; code_i = code;
      @(posedge clk); #1;
      start_i = 0; abort_i = 0; code_i = ~code;
      t_acc = cyc;
      check("busy_after_start", {31'd0, busy_o}, 1);
   endtask

   task automatic finish_code(input string tag);
      for (int i = 0; i < 400 && !done_flag; i++) @(posedge clk);
      check({tag, "_done_seen"}, {31'd0, done_flag}, 1);
      check({tag, "_done_cycle"}, done_cyc, t_acc + exp_p * (GAP + 1));
      check({tag, "_busy_cycles"}, busy_cnt, exp_p * (GAP + 1));
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      check({tag, "_decoded"}, {16'd0, got_code}, {16'd0, exp_code});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", {28'd0, next_o, enter_o, busy_o, done_o}, 0);
      rst_n = 1;
      go(16'h2103, 0);
      finish_code("c2103");
      check("unlock_right", {31'd0, got_code == LOCK_CODE}, 1);
      go(16'h0000, 0);
      finish_code("c0000");
      go(16'hFFFF, 0);
      finish_code("cFFFF");
      go(16'h1234, 0);
      repeat (10) @(posedge clk);
      #1 start_i = 1; code_i = 16'h9999;
      @(posedge clk); #1 start_i = 0;
      finish_code("ignore_start");
      go(16'h2103, 0);
      for (int i = 0; i < 100 && n_pulse < 3; i++) @(posedge clk);
      check("abort_reach3", n_pulse, 3);
      #1 abort_i = 1;
      @(posedge clk); #1 abort_i = 0;
      check("abort_outputs", {29'd0, next_o, enter_o, busy_o}, 0);
      repeat (30) @(posedge clk);
      check("abort_no_done", {31'd0, done_flag}, 0);
      check("abort_pulses", n_pulse, 3);
      go(16'h3000, 0);
      for (int i = 0; i < 50 && !next_o; i++) @(negedge clk);
      check("rst_in_next", {31'd0, next_o}, 1);
      rst_n = 0;
      #1;
      check("async_rst", {30'd0, next_o, busy_o}, 0);
      @(posedge clk); #1 rst_n = 1;
      go(16'h3000, 0);
      finish_code("after_rst");
      go(16'h0102, 1);
      finish_code("start_wins");
      go(16'h2203, 0);
      finish_code("c2203");
      check("unlock_wrong", {31'd0, got_code == LOCK_CODE}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
